// File: rtl/button_panel_ctl.sv
// -----------------------------------------------------------------------------
// button_panel_ctl
//
// Row of N_BTN clickable on-screen buttons laid out left to right. Turns the
// raw mouse level and cursor position into per-button fill colours, a
// one-cycle click pulse and a persistent selection vector. A click is a press
// and a release that both land inside the same button.
//
// Optional feature macro: BTN_HOVER_EN
//   defined   -> an unpressed, unselected button under the cursor (mouse_left
//                low) shows COLOR_HOVER
//   undefined -> such a button shows COLOR_IDLE
//
// Ports:
//   clk          in   pixel clock
//   rst_n        in   asynchronous reset, active-low
//   mouse_left   in   left mouse button level
//   mouse_xpos   in   cursor x [11:0]
//   mouse_ypos   in   cursor y [11:0]
//   clear        in   synchronous clear of the selection
//   color_out    out  fill colour, button i at [12*i+11:12*i]
//   click_pulse  out  one-cycle pulse on a completed click of button i
//   selected     out  persistent selection state
//   busy         out  high while a press is in progress
// -----------------------------------------------------------------------------
module button_panel_ctl #(
  parameter int          N_BTN       = 4,
  parameter int          X_POS       = 112,
  parameter int          Y_POS       = 284,
  parameter int          WIDTH       = 180,
  parameter int          HEIGHT      = 200,
  parameter int          GAP         = 20,
  parameter int          TOGGLE      = 0,
  parameter logic [11:0] COLOR_IDLE  = 12'h0_A_A,
  parameter logic [11:0] COLOR_SEL   = 12'h0_F_0,
  parameter logic [11:0] COLOR_PRESS = 12'hF_F_0,
  parameter logic [11:0] COLOR_HOVER = 12'h0_C_C
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mouse_left,
  input  logic [11:0]           mouse_xpos,
  input  logic [11:0]           mouse_ypos,
  input  logic                  clear,
  output logic [12*N_BTN-1:0]   color_out,
  output logic [N_BTN-1:0]      click_pulse,
  output logic [N_BTN-1:0]      selected,
  output logic                  busy
);

  localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMED    = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 left_q;
  logic [IDX_W-1:0]     arm_q, arm_d;
  logic [N_BTN-1:0]     click_q, click_d;
  logic [N_BTN-1:0]     sel_q, sel_d;
  logic                 busy_q, busy_d;
  logic [12*N_BTN-1:0]  color_q, color_d;

  logic [N_BTN-1:0]     hit;
  logic                 hit_any;
  logic [IDX_W-1:0]     hit_idx;
  logic                 press, release_evt;
  logic                 click_now;
  logic [N_BTN-1:0]     arm_onehot;

  // Hit test with strict bounds. Coordinates are widened to 13 bits so a
  // right/bottom edge just past 4095 still compares correctly.
  logic [12:0] x13, y13;
  assign x13 = {1'b0, mouse_xpos};
  assign y13 = {1'b0, mouse_ypos};

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_hit
      localparam logic [12:0] XL = 13'(X_POS + gi * (WIDTH + GAP));
      localparam logic [12:0] XR = 13'(X_POS + gi * (WIDTH + GAP) + WIDTH);
      localparam logic [12:0] YT = 13'(Y_POS);
      localparam logic [12:0] YB = 13'(Y_POS + HEIGHT);
      assign hit[gi] = (x13 > XL) && (x13 < XR) && (y13 > YT) && (y13 < YB);
    end
  endgenerate

  // Buttons never overlap, so a plain scan yields the single hit index.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (hit[i]) hit_idx = IDX_W'(i);
    end
  end
  assign hit_any = |hit;

  assign press       = mouse_left & ~left_q;
  assign release_evt = ~mouse_left & left_q;

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      arm_onehot[i] = (arm_q == IDX_W'(i));
    end
  end

  // Next-state, click and selection logic.
  always_comb begin
    state_d   = state_q;
    arm_d     = arm_q;
    click_now = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press) begin
          if (hit_any) begin
            state_d = S_ARMED;
            arm_d   = hit_idx;
          end else begin
            state_d = S_WAIT_REL;
          end
        end
      end
      S_ARMED: begin
        if (release_evt) begin
          state_d = S_IDLE;
          // Releasing anywhere other than the armed button cancels the click.
          click_now = hit_any && (hit_idx == arm_q);
        end
      end
      S_WAIT_REL: begin
        if (release_evt) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    click_d = click_now ? arm_onehot : '0;

    sel_d = sel_q;
    if (click_now) begin
      if (TOGGLE != 0) sel_d = sel_q ^ arm_onehot;
      else             sel_d = arm_onehot;
    end
    // Clear wins over a simultaneous click; the pulse still goes out.
    if (clear) sel_d = '0;

    busy_d = (state_d != S_IDLE);

    // Colours follow the post-update state so they line up with busy/selected.
    for (int i = 0; i < N_BTN; i++) begin
      if ((state_d == S_ARMED) && (arm_d == IDX_W'(i)) && hit[i])
        color_d[12*i +: 12] = COLOR_PRESS;
      else if (sel_d[i])
        color_d[12*i +: 12] = COLOR_SEL;
`ifdef BTN_HOVER_EN
      else if (hit[i] && !mouse_left)
        color_d[12*i +: 12] = COLOR_HOVER;
`endif
      else
        color_d[12*i +: 12] = COLOR_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      // Starting "high" means a button held through reset gives no press edge.
      left_q  <= 1'b1;
      arm_q   <= '0;
      click_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      color_q <= {N_BTN{COLOR_IDLE}};
    end else begin
      state_q <= state_d;
      left_q  <= mouse_left;
      arm_q   <= arm_d;
      click_q <= click_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      color_q <= color_d;
    end
  end

  assign color_out   = color_q;
  assign click_pulse = click_q;
  assign selected    = sel_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_button_panel_ctl.sv
// -----------------------------------------------------------------------------
// tb_button_panel_ctl
//
// Drives two instances (radio and toggle selection) with a shared mouse and
// compares registered outputs against expectations queued at drive time.
// Geometry: 3 buttons, x 101..299 / 321..519 / 541..739, y 101..199.
// -----------------------------------------------------------------------------
module tb_button_panel_ctl;

  localparam logic [11:0] CI = 12'h0AA;
  localparam logic [11:0] CS = 12'h0F0;
  localparam logic [11:0] CP = 12'hFF0;
`ifdef BTN_HOVER_EN
  localparam logic [11:0] CH = 12'h0CC;
`else
  localparam logic [11:0] CH = 12'h0AA;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mouse_left;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic        clear;

  logic [35:0] color0, color1;
  logic [2:0]  click0, click1, sel0, sel1;
  logic        busy0, busy1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        dut;
    logic [2:0]  click;
    logic [2:0]  sel;
    logic        busy;
    logic [35:0] col;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  button_panel_ctl #(
    .N_BTN(3), .X_POS(100), .Y_POS(100), .WIDTH(200), .HEIGHT(100), .GAP(20),
    .TOGGLE(0)
  ) dut_radio (
    .clk(clk), .rst_n(rst_n), .mouse_left(mouse_left),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .clear(clear),
    .color_out(color0), .click_pulse(click0), .selected(sel0), .busy(busy0)
  );

  button_panel_ctl #(
    .N_BTN(3), .X_POS(100), .Y_POS(100), .WIDTH(200), .HEIGHT(100), .GAP(20),
    .TOGGLE(1)
  ) dut_toggle (
    .clk(clk), .rst_n(rst_n), .mouse_left(mouse_left),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .clear(clear),
    .color_out(color1), .click_pulse(click1), .selected(sel1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // One transaction: drive inputs, queue the expectation, then after the
  // sampling edge pop it and compare against the chosen instance.
  task automatic step(input string tag, input bit d, input int x, input int y,
                      input bit ml, input bit clr, input logic [2:0] e_click,
                      input logic [2:0] e_sel, input bit e_busy,
                      input logic [35:0] e_col);
    exp_t e;
    exp_t p;
    string t;
    mouse_xpos = 12'(x);
    mouse_ypos = 12'(y);
    mouse_left = ml;
    clear      = clr;
    e.dut = d; e.click = e_click; e.sel = e_sel; e.busy = e_busy; e.col = e_col;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    p = exp_q.pop_front();
    t = tag_q.pop_front();
    if (p.dut) begin
      check({t, ".click"}, 64'(click1), 64'(p.click));
      check({t, ".sel"},   64'(sel1),   64'(p.sel));
      check({t, ".busy"},  64'(busy1),  64'(p.busy));
      check({t, ".color"}, 64'(color1), 64'(p.col));
    end else begin
      check({t, ".click"}, 64'(click0), 64'(p.click));
      check({t, ".sel"},   64'(sel0),   64'(p.sel));
      check({t, ".busy"},  64'(busy0),  64'(p.busy));
      check({t, ".color"}, 64'(color0), 64'(p.col));
    end
    $display("txn %-10s dut=%0d x=%0d y=%0d ml=%0b clr=%0b", t, p.dut, x, y, ml, clr);
  endtask

  initial begin
    rst_n = 1'b0; mouse_left = 1'b1; clear = 1'b0;
    mouse_xpos = 12'd400; mouse_ypos = 12'd150;
    repeat (3) @(posedge clk);
    #1;
    check("rst.color", 64'(color0), 64'({CI, CI, CI}));
    check("rst.click", 64'(click0), 64'(3'b000));
    check("rst.sel",   64'(sel0),   64'(3'b000));
    check("rst.busy",  64'(busy0),  64'(1'b0));
    rst_n = 1'b1;

    // Radio instance
    step("held",    0, 400, 150, 1, 0, 3'b000, 3'b000, 0, {CI, CI, CI});
    step("rel_ign", 0, 400, 150, 0, 0, 3'b000, 3'b000, 0, {CI, CH, CI});
    step("hover0",  0, 200, 150, 0, 0, 3'b000, 3'b000, 0, {CI, CI, CH});
    step("press1",  0, 400, 150, 1, 0, 3'b000, 3'b000, 1, {CI, CP, CI});
    step("hold1",   0, 410, 160, 1, 0, 3'b000, 3'b000, 1, {CI, CP, CI});
    step("click1",  0, 410, 160, 0, 0, 3'b010, 3'b010, 0, {CI, CS, CI});
    step("after1",  0, 410, 160, 0, 0, 3'b000, 3'b010, 0, {CI, CS, CI});
    step("dpress",  0, 400, 150, 1, 0, 3'b000, 3'b010, 1, {CI, CP, CI});
    step("dragoff", 0, 150, 150, 1, 0, 3'b000, 3'b010, 1, {CI, CS, CI});
    step("dcancel", 0, 150, 150, 0, 0, 3'b000, 3'b010, 0, {CI, CS, CH});
    step("x320",    0, 320, 150, 0, 0, 3'b000, 3'b010, 0, {CI, CS, CI});
    step("x520",    0, 520, 150, 0, 0, 3'b000, 3'b010, 0, {CI, CS, CI});
    step("wpress",  0, 320, 150, 1, 0, 3'b000, 3'b010, 1, {CI, CS, CI});
    step("wmove",   0, 400, 150, 1, 0, 3'b000, 3'b010, 1, {CI, CS, CI});
    step("wrel",    0, 400, 150, 0, 0, 3'b000, 3'b010, 0, {CI, CS, CI});
    step("gpress",  0, 200, 150, 1, 0, 3'b000, 3'b010, 1, {CI, CS, CP});
    step("grel",    0, 200, 150, 0, 0, 3'b001, 3'b001, 0, {CI, CI, CS});

    // Toggle instance (selection is 3'b011 from the clicks above)
    step("clr",     1, 600, 150, 0, 1, 3'b000, 3'b000, 0, {CH, CI, CI});
    step("t_p1",    1, 600, 150, 1, 0, 3'b000, 3'b000, 1, {CP, CI, CI});
    step("t_c1",    1, 600, 150, 0, 0, 3'b100, 3'b100, 0, {CS, CI, CI});
    step("t_p2",    1, 600, 150, 1, 0, 3'b000, 3'b100, 1, {CP, CI, CI});
    step("t_c2",    1, 600, 150, 0, 0, 3'b100, 3'b000, 0, {CH, CI, CI});
    step("t_p3",    1, 600, 150, 1, 0, 3'b000, 3'b000, 1, {CP, CI, CI});
    step("t_c3",    1, 600, 150, 0, 0, 3'b100, 3'b100, 0, {CS, CI, CI});
    step("t_p4",    1, 600, 150, 1, 0, 3'b000, 3'b100, 1, {CP, CI, CI});

    // Reset in the middle of a press
    rst_n = 1'b0;
    #2;
    check("mrst.busy",  64'(busy1),  64'(1'b0));
    check("mrst.sel",   64'(sel1),   64'(3'b000));
    check("mrst.click", 64'(click1), 64'(3'b000));
    check("mrst.color", 64'(color1), 64'({CI, CI, CI}));
    @(posedge clk);
    #1;
    mouse_left = 1'b0;
    rst_n = 1'b1;

    step("post_rst", 1, 600, 150, 0, 0, 3'b000, 3'b000, 0, {CH, CI, CI});
    step("t_p5",     1, 600, 150, 1, 0, 3'b000, 3'b000, 1, {CP, CI, CI});
    step("t_c5",     1, 600, 150, 0, 0, 3'b100, 3'b100, 0, {CS, CI, CI});
    step("t_p6",     1, 600, 150, 1, 0, 3'b000, 3'b100, 1, {CP, CI, CI});
    step("t_cclr",   1, 600, 150, 0, 1, 3'b100, 3'b000, 0, {CH, CI, CI});
    step("t_idle",   1, 600, 150, 0, 0, 3'b000, 3'b000, 0, {CH, CI, CI});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
